// File: rtl/mem_responder.sv
// Word-organised RAM target answering load/store requests with byte-lane writes.
// Latency: response valid WAIT_CYCLES+1 cycles after the accepting edge.
// Backpressure: one transaction in flight; req_ready low until the response handshakes.
// Optional MEM_RESP_ERR_EN: flags out-of-range addresses and illegal byte-enable patterns.
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    // Access operands: with zero wait states the array is touched on the accepting
    // edge, so the live request is used; otherwise the latched copy is.
    logic          from_idle;
    logic [31:0]   acc_addr;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata;
    logic [31:0]   acc_off;
    logic [AW-1:0] acc_idx;
    logic          acc_err;
    logic          enter_resp;
    logic          mem_we;
    logic          unused_off;

    assign from_idle  = (state_q == ST_IDLE);
    assign acc_addr   = from_idle ? req_addr  : addr_q;
    assign acc_be     = from_idle ? req_be    : be_q;
    assign acc_wdata  = from_idle ? req_wdata : wdata_q;
    assign acc_off    = acc_addr - BASE_ADDR;
    assign acc_idx    = acc_off[AW+1:2];
    assign unused_off = ^{acc_off[31:AW+2], acc_off[1:0]};

`ifdef MEM_RESP_ERR_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    // Out-of-window addresses and byte-enable shapes other than byte/half/word.
    always_comb begin
        acc_err = ({1'b0, acc_off} >= SPAN);
        case (acc_be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ;
            default: acc_err = 1'b1;
        endcase
    end
`else
    assign acc_err = 1'b0;
`endif

    assign enter_resp = (from_idle && req_valid && (WAIT_CYCLES == 0)) ||
                        ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    assign mem_we     = rst_n && enter_resp && (acc_be != 4'd0) && !acc_err;

    // Next-state and registered-output computation for the request/response FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = ((acc_be == 4'd0) && !acc_err) ? mem[acc_idx] : 32'd0;
        end
        req_ready_d = (state_d == ST_IDLE);
    end

    // Control and response registers; a reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane RAM write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = !req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance A (WAIT_CYCLES=2) gets directed and random traffic
// against a word-array reference model; instance B (WAIT_CYCLES=0) gets a back-to-back stream.
// Expectations follow MEM_RESP_ERR_EN when the bench is built with it defined.
module tb_mem_responder;

    localparam int WA = 2;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ref_a [1024];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WA), .BASE_ADDR(32'h0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .req_be(a_req_be), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_be(b_req_be), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a plain word array; byte lanes merged per enable bit.
    function automatic void model_a(input logic [31:0] addr, input logic [3:0] be,
                                    input logic [31:0] wd, output logic [31:0] rd,
                                    output logic er);
        int unsigned idx;
        idx = (addr >> 2) % 1024;
        er  = 1'b0;
`ifdef MEM_RESP_ERR_EN
        er = (addr >= 32'h1000) ||
             !(be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                          4'b0011, 4'b1100, 4'b1111});
`endif
        rd = 32'd0;
        if (!er) begin
            if (be == 4'd0) begin
                rd = ref_a[idx];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_a[idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endfunction

    // One full transaction on instance A, entered and left just after a rising edge.
    task automatic run_a(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                         input int stall, output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          n;
        model_a(addr, be, wd, exp_rd, exp_er);
        a_req_valid = 1'b1; a_req_addr = addr; a_req_be = be; a_req_wdata = wd;
        a_rsp_ready = 1'b0;
        n = 0;
        while (a_req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        a_req_addr  = $urandom; a_req_be = 4'($urandom); a_req_wdata = $urandom;
        a_rsp_ready = (stall == 0);
        n = 1;
        @(negedge clk);
        while (a_rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("latency", n, WA + 1);
        chk("rdata", a_rsp_rdata, exp_rd);
        chk("err", 32'(a_rsp_err), 32'(exp_er));
        rd = a_rsp_rdata;
        er = a_rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("bp_valid", 32'(a_rsp_valid), 32'd1);
            chk("bp_rdata", a_rsp_rdata, exp_rd);
            chk("bp_ready", 32'(a_req_ready), 32'd0);
            chk("bp_busy", 32'(a_busy), 32'd1);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_ready", 32'(a_req_ready), 32'd1);
        chk("post_valid", 32'(a_rsp_valid), 32'd0);
        chk("post_busy", 32'(a_busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a_ready"}, 32'(a_req_ready), 32'd1);
        chk({tag, "_a_valid"}, 32'(a_rsp_valid), 32'd0);
        chk({tag, "_a_rdata"}, a_rsp_rdata, 32'd0);
        chk({tag, "_a_err"}, 32'(a_rsp_err), 32'd0);
        chk({tag, "_a_busy"}, 32'(a_busy), 32'd0);
    endtask

    initial begin : main
        logic [31:0] rd, wd, addr;
        logic        er;
        logic [3:0]  be;
        logic [3:0]  legal_be [8];
        logic [31:0] b_data [4];
        int          acc_cyc [8];
        int          k, r;

        legal_be = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_addr = '0; a_req_be = '0; a_req_wdata = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_be = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        chk("reset_b_ready", 32'(b_req_ready), 32'd1);
        chk("reset_b_valid", 32'(b_rsp_valid), 32'd0);
        chk("reset_b_busy", 32'(b_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Give words 0..63 defined contents before any read.
        for (int w = 0; w < 64; w++) run_a(32'(w * 4), 4'hF, $urandom, 0, rd, er);

        // Full-word write then read-back.
        run_a(32'h10, 4'hF, 32'hDEADBEEF, 0, rd, er);
        chk("wr_rsp_zero", rd, 32'd0);
        run_a(32'h10, 4'h0, 32'h0, 0, rd, er);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);

        // Byte-lane merge.
        run_a(32'h20, 4'hF, 32'h11223344, 0, rd, er);
        run_a(32'h20, 4'b0100, 32'hAAAAAAAA, 0, rd, er);
        run_a(32'h20, 4'h0, 32'h0, 0, rd, er);
        chk("merge_b2", rd, 32'h11AA3344);
        run_a(32'h20, 4'b1100, 32'h55665566, 0, rd, er);
        run_a(32'h20, 4'h0, 32'h0, 0, rd, er);
        chk("merge_hi", rd, 32'h55663344);

        // Back-pressure: five extra cycles with rsp_ready low.
        run_a(32'h20, 4'h0, 32'h0, 5, rd, er);

        // Reset while a write to 0x30 is in WAIT must not touch RAM.
        run_a(32'h30, 4'hF, 32'h0, 0, rd, er);
        a_req_valid = 1'b1; a_req_addr = 32'h30; a_req_be = 4'hF; a_req_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        chk("mid_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_a(32'h30, 4'h0, 32'h0, 0, rd, er);
        chk("midrst_ram", rd, 32'h0);

        // Out-of-range address and illegal byte-enable shape.
        run_a(32'h1000, 4'hF, 32'h12345678, 0, rd, er);
`ifdef MEM_RESP_ERR_EN
        chk("oob_err", 32'(er), 32'd1);
`endif
        run_a(32'h0, 4'h0, 32'h0, 0, rd, er);
        chk("rd0_err", 32'(er), 32'd0);
`ifndef MEM_RESP_ERR_EN
        chk("oob_wraps", rd, 32'h12345678);
`endif
        run_a(32'h40, 4'b0101, 32'hCAFEF00D, 0, rd, er);
`ifdef MEM_RESP_ERR_EN
        chk("be0101_err", 32'(er), 32'd1);
`endif
        run_a(32'h40, 4'h0, 32'h0, 0, rd, er);

        // Random traffic over the initialised window, occasionally aliased or odd enables.
        for (int t = 0; t < 80; t++) begin
            addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = addr + 32'h1000 * $urandom_range(1, 3);
            be = ($urandom_range(0, 1) == 0) ? 4'h0 : legal_be[$urandom_range(1, 7)];
            if ($urandom_range(0, 5) == 0) be = 4'($urandom);
            wd = $urandom;
            run_a(addr, be, wd, $urandom_range(0, 2), rd, er);
        end

        // Instance B: zero wait states, request held valid, four writes then four reads.
        for (int i = 0; i < 4; i++) b_data[i] = $urandom;
        b_rsp_ready = 1'b1;
        k = 0; r = 0;
        for (int c = 0; c < 60 && r < 8; c++) begin
            b_req_valid = (k < 8);
            b_req_addr  = 32'((k % 4) * 4);
            b_req_be    = (k < 4) ? 4'hF : 4'h0;
            b_req_wdata = (k < 4) ? b_data[k % 4] : 32'h0;
            @(negedge clk);
            if (b_rsp_valid === 1'b1) begin
                chk("b_rdata", b_rsp_rdata, (r < 4) ? 32'h0 : b_data[r % 4]);
                chk("b_latency", 32'(c - acc_cyc[r]), 32'd1);
                if (r > 0) chk("b_spacing", 32'(acc_cyc[r] - acc_cyc[r-1]), 32'd2);
                r++;
            end
            if (b_req_ready === 1'b1 && b_req_valid) begin
                acc_cyc[k] = c;
                k++;
            end
            @(posedge clk); #1;
        end
        b_req_valid = 1'b0;
        chk("b_count", r, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
